// File: rtl/instruction_sequencer.sv
// Instruction feeder for the cpu: buffers host words in a FIFO and issues one per clock,
// inserting NOP bubbles around burst reads, operates and burst-write data beats.
module instruction_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 8,   // power of two, >= 8
    parameter int unsigned OPERATE_WAIT = 8    // must fit the 4-bit wait counter
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic [15:0]                 host_instruction_in,
    input  logic                        host_valid_in,
    output logic                        host_ready_out,
    output logic [15:0]                 current_instruction_out,
    output logic                        busy_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [15:0]   NOP         = 16'h0000;
    localparam logic [3:0]    READ_GAP    = 4'd9;
    localparam logic [3:0]    BURST_BEATS = 4'd5;
    localparam logic [CW-1:0] BURST_WORDS = CW'(6);

    typedef enum logic [1:0] {
        ISSUE,
        BURST_DATA,
        READ_WAIT,
        OP_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_nxt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [15:0]   instr_nxt;

    logic          is_burst_write;
    logic          is_burst_read;
    logic          is_operate;
    logic          burst_ready;

    assign head           = mem[rd_ptr];
    assign fifo_empty     = (count == CW'(0));
    assign host_ready_out = (count < CW'(FIFO_DEPTH));
    assign push           = host_valid_in && host_ready_out;
    assign fifo_count_out = count;
    assign busy_out       = (state != ISSUE);

    // Head decode; only meaningful while issuing, burst data is never decoded
    assign is_burst_write = (head[1:0] == 2'b11) &&  head[2];
    assign is_burst_read  = (head[1:0] == 2'b11) && !head[2];
    assign is_operate     = (head[1:0] == 2'b10);
    assign burst_ready    = (count >= BURST_WORDS);

    // State register
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state    <= ISSUE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            ISSUE: begin
                if (!fifo_empty) begin
                    if (is_burst_write) begin
                        if (burst_ready) begin
                            state_nxt    = BURST_DATA;
                            wait_cnt_nxt = BURST_BEATS;
                        end
                    end else if (is_burst_read) begin
                        state_nxt    = READ_WAIT;
                        wait_cnt_nxt = READ_GAP;
                    end else if (is_operate) begin
                        state_nxt    = OP_WAIT;
                        wait_cnt_nxt = 4'(OPERATE_WAIT);
                    end
                end
            end
            default: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ISSUE;
                end
            end
        endcase
    end

    // Output logic: pop strobe and next word to present
    always_comb begin
        pop       = 1'b0;
        instr_nxt = NOP;
        unique case (state)
            ISSUE: begin
                if (!fifo_empty && !(is_burst_write && !burst_ready)) begin
                    pop       = 1'b1;
                    instr_nxt = head;
                end
            end
            BURST_DATA: begin
                pop       = !fifo_empty;
                instr_nxt = head;
            end
            default: begin
                pop       = 1'b0;
                instr_nxt = NOP;
            end
        endcase
    end

    // FIFO pointers, occupancy and the registered instruction output
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rd_ptr                  <= '0;
            wr_ptr                  <= '0;
            count                   <= '0;
            current_instruction_out <= NOP;
        end else begin
            current_instruction_out <= instr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[wr_ptr] <= host_instruction_in;
        end
    end

endmodule
